// File: rtl/mii2mii.sv
// MII-to-MII nibble repeater: samples an input MII stream, buffers {sof, nibble}
// in a FIFO and replays it on a second, slower-or-equal MII clock.
module mii2mii #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       SW0,
  output logic [7:0] LED,
  input  logic       miiI_clk,
  input  logic       miiI_en,
  input  logic [0:3] miiI_d,
  input  logic       miiO_clk,
  output logic       miiO_en,
  output logic [0:3] miiO_d
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic         si_clk, si_clk_q, si_en;
  logic [0:3]   si_d;
  logic         en_last, armed;
  logic         so_clk, so_clk_q;
  logic [6:0]   frame_cnt;
  logic         ovf;

  logic [4:0]   mem [FIFO_DEPTH];
  logic [AW:0]  wptr, rptr;
  logic [4:0]   head;
  logic         empty, full;
  logic         in_stb, out_stb;
  logic         wr_req, wr, rd, sof;

  assign in_stb  = si_clk_q & ~si_clk;
  assign out_stb = ~so_clk_q & so_clk;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // armed stays low after reset until an idle strobe is seen, so a frame
  // already in progress at reset release is dropped as a whole.
  assign sof    = ~en_last;
  assign wr_req = in_stb & si_en & armed;
  assign wr     = wr_req & ~full;
  assign rd     = out_stb & ~empty & ~(head[4] & miiO_en);

  assign LED = {ovf, frame_cnt};

  always_ff @(posedge clk) begin
    if (SW0) begin
      si_clk    <= 1'b0;
      si_clk_q  <= 1'b0;
      si_en     <= 1'b0;
      si_d      <= 4'b0000;
      so_clk    <= 1'b0;
      so_clk_q  <= 1'b0;
      en_last   <= 1'b0;
      armed     <= 1'b0;
      frame_cnt <= 7'd0;
      ovf       <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      miiO_en   <= 1'b0;
      miiO_d    <= 4'b0000;
    end else begin
      si_clk   <= miiI_clk;
      si_clk_q <= si_clk;
      si_en    <= miiI_en;
      si_d     <= miiI_d;
      so_clk   <= miiO_clk;
      so_clk_q <= so_clk;

      if (in_stb) begin
        en_last <= si_en;
        if (!si_en) armed <= 1'b1;
      end
      if (wr_req && sof) frame_cnt <= frame_cnt + 7'd1;
      if (wr_req && full) ovf <= 1'b1;

      if (wr) wptr <= wptr + (AW+1)'(1);
      if (rd) rptr <= rptr + (AW+1)'(1);

      if (out_stb) begin
        if (rd) begin
          miiO_en <= 1'b1;
          miiO_d  <= head[3:0];
        end else begin
          // empty, or a new frame is waiting behind an active one: idle nibble
          miiO_en <= 1'b0;
          miiO_d  <= 4'b0000;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= {sof, si_d};
  end

endmodule

// File: tb/tb_mii2mii.sv
// Randomized bench for mii2mii: frames go into an expected-nibble queue and a
// sink on miiO_clk rising edges reassembles frames and compares them.
module tb_mii2mii;

  logic       clk = 1'b0;
  logic       SW0 = 1'b1;
  logic [7:0] LED;
  logic       miiI_clk = 1'b0;
  logic       miiI_en = 1'b0;
  logic [0:3] miiI_d = 4'b0000;
  logic       miiO_clk = 1'b0;
  logic       miiO_en;
  logic [0:3] miiO_d;

  bit o_run = 1'b1;
  int n_err = 0;
  int n_chk = 0;
  int exp_q[$];
  int exp_len[$];
  int fr[$];
  int cur_len = 0;
  int ocnt = 0;
  int lat_mark = 0;
  bit lat_armed = 1'b0;
  int fcount = 0;

  mii2mii #(.FIFO_DEPTH(64)) dut (
    .clk(clk), .SW0(SW0), .LED(LED),
    .miiI_clk(miiI_clk), .miiI_en(miiI_en), .miiI_d(miiI_d),
    .miiO_clk(miiO_clk), .miiO_en(miiO_en), .miiO_d(miiO_d)
  );

  always #10 clk = ~clk;
  always #20 miiI_clk = ~miiI_clk;

  // Output nibble clock, 44 period, rises at 3+44n; held low while o_run=0.
  initial begin
    #3;
    forever begin
      if (o_run) miiO_clk = 1'b1;
      #22;
      miiO_clk = 1'b0;
      #22;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sink: what a PHY would latch on each miiO_clk rising edge.
  always @(posedge miiO_clk) begin
    ocnt++;
    if (miiO_en) begin
      if (cur_len == 0 && lat_armed) begin
        chk("first_nibble_latency_ok",
            int'((ocnt - lat_mark) >= 1 && (ocnt - lat_mark) <= 4), 1);
        lat_armed = 1'b0;
      end
      if (exp_q.size() == 0) chk("extra_nibble_en", int'(miiO_en), 0);
      else chk("nibble", int'(miiO_d), exp_q.pop_front());
      cur_len++;
    end else begin
      chk("idle_d", int'(miiO_d), 0);
      if (cur_len > 0) begin
        if (exp_len.size() == 0) chk("extra_frame_len", cur_len, 0);
        else chk("frame_len", cur_len, exp_len.pop_front());
        cur_len = 0;
      end
    end
  end

  task automatic send_frame(input int gap, input int keep, input bit measure);
    int stored;
    stored = (keep < fr.size()) ? keep : fr.size();
    fcount++;
    for (int i = 0; i < stored; i++) exp_q.push_back(fr[i]);
    exp_len.push_back(stored);
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge miiI_clk);
      if (i == 0 && measure) begin
        lat_mark = ocnt;
        lat_armed = 1'b1;
      end
      miiI_en = 1'b1;
      miiI_d  = 4'(fr[i]);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge miiI_clk);
      miiI_en = 1'b0;
      miiI_d  = 4'b0000;
    end
  endtask

  task automatic rand_frame(input int len);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(int'($urandom_range(0, 15)));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && (exp_q.size() > 0 || exp_len.size() > 0 || cur_len > 0); i++)
      @(posedge clk);
    chk("drain_left", exp_q.size() + exp_len.size() + cur_len, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 SW0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 SW0 = 1'b0;
    fcount = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hdr[14];
    hdr = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
            8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'h12, 8'h34};

    do_reset();
    @(negedge clk);
    chk("rst_led", int'(LED), 0);
    chk("rst_en", int'(miiO_en), 0);
    chk("rst_d", int'(miiO_d), 0);
    repeat (10) @(posedge miiO_clk);
    @(negedge clk);
    chk("idle_en", int'(miiO_en), 0);

    // Back-to-back frames with a single idle input nibble between them.
    rand_frame(20); send_frame(1, 1000, 1'b0);
    rand_frame(20); send_frame(1, 1000, 1'b0);
    wait_drain();
    @(negedge clk);
    chk("b2b_frame_cnt", int'(LED[6:0]), 2);

    // Preamble, SFD, Ethernet header low nibble first, short payload.
    fr.delete();
    repeat (15) fr.push_back(4'b1010);
    fr.push_back(4'b1011);
    for (int b = 0; b < 14; b++) begin
      fr.push_back(hdr[b] & 15);
      fr.push_back((hdr[b] >> 4) & 15);
    end
    for (int i = 0; i < 10; i++) fr.push_back(int'($urandom_range(0, 15)));
    send_frame(4, 1000, 1'b1);
    wait_drain();

    // 111-nibble frame: input 40 vs output 44 per nibble.
    rand_frame(111); send_frame(4, 1000, 1'b1);
    wait_drain();
    @(negedge clk);
    chk("rate_no_ovf", int'(LED[7]), 0);

    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 4; f++) begin
        rand_frame(int'($urandom_range(8, 100)));
        send_frame(int'($urandom_range(1, 3)), 1000, 1'b0);
      end
      wait_drain();
    end
    @(negedge clk);
    chk("rand_no_ovf", int'(LED[7]), 0);
    chk("rand_frame_cnt", int'(LED[6:0]), fcount % 128);

    // Stalled output: only the first 64 nibbles fit, the rest are dropped.
    o_run = 1'b0;
    repeat (4) @(posedge clk);
    rand_frame(100); send_frame(3, 64, 1'b0);
    @(negedge clk);
    chk("ovf_set", int'(LED[7]), 1);
    chk("ovf_no_output", int'(miiO_en), 0);
    o_run = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("ovf_sticky", int'(LED[7]), 1);
    chk("ovf_frame_cnt", int'(LED[6:0]), fcount % 128);

    do_reset();
    @(negedge clk);
    chk("rst2_led", int'(LED), 0);
    chk("rst2_en", int'(miiO_en), 0);
    repeat (6) @(posedge miiO_clk);
    rand_frame(30); send_frame(3, 1000, 1'b1);
    wait_drain();
    @(negedge clk);
    chk("post_rst_frame_cnt", int'(LED[6:0]), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
